// File: rtl/pipe_trace_pkg.sv
// rtl/pipe_trace_pkg.sv - shared state encodings and width helpers for the pipeline trace buffer
package pipe_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_POST    = 2'd2,
    ST_READOUT = 2'd3
  } trace_state_e;

  // count must be able to hold DEPTH itself, hence one bit more than the pointers
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - DEPTH x DW trace storage, synchronous write, asynchronous read, no reset
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// rtl/pipe_trace_buffer.sv - circular probe capture with trigger, post-trigger window and oldest-first readout
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int CH    = 8,
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int POST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CH*W-1:0]               probe,
  input  logic                          sample_en,
  input  logic                          arm,
  input  logic                          trig,
  input  logic                          abort,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [CH*W-1:0]               rd_data,
  output logic                          rd_last,
  output logic [1:0]                    state,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam int DW = CH * W;

  trace_state_e  state_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] post_cnt;

  logic          do_write;
  logic [PW-1:0] wr_ptr_adv;
  logic [CW-1:0] count_adv;
  logic [PW-1:0] rd_ptr_entry;
  logic [DW-1:0] ram_rdata;

  // Pointer and fill level as they will be after this edge's capture, so the
  // readout start can be taken even when the final sample lands on the same edge.
  assign do_write     = (state_q == ST_ARMED || state_q == ST_POST) && sample_en && !abort;
  assign wr_ptr_adv   = do_write ? wr_ptr + PW'(1) : wr_ptr;
  assign count_adv    = (do_write && count != CW'(DEPTH)) ? count + CW'(1) : count;
  assign rd_ptr_entry = wr_ptr_adv - count_adv[PW-1:0];

  trace_ram #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_ram (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_ptr),
    .wdata (probe),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
    end else if (abort) begin
      state_q  <= ST_IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          wr_ptr <= wr_ptr_adv;
          count  <= count_adv;
          if (trig) begin
            post_cnt <= PW'(POST);
            if (POST == 0) begin
              state_q <= ST_READOUT;
              rd_ptr  <= rd_ptr_entry;
            end else begin
              state_q <= ST_POST;
            end
          end
        end
        ST_POST: begin
          wr_ptr <= wr_ptr_adv;
          count  <= count_adv;
          if (sample_en) begin
            post_cnt <= post_cnt - PW'(1);
            if (post_cnt == PW'(1)) begin
              state_q <= ST_READOUT;
              rd_ptr  <= rd_ptr_entry;
            end
          end
        end
        ST_READOUT: begin
          if (count == '0) begin
            state_q  <= ST_IDLE;
            wr_ptr   <= '0;
            post_cnt <= '0;
          end else if (rd_ready) begin
            rd_ptr <= rd_ptr + PW'(1);
            count  <= count - CW'(1);
            if (count == CW'(1)) begin
              state_q  <= ST_IDLE;
              wr_ptr   <= '0;
              post_cnt <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Data is gated so stale or never-written RAM words are never visible.
  assign state    = state_q;
  assign rd_valid = (state_q == ST_READOUT) && (count != '0);
  assign rd_last  = rd_valid && (count == CW'(1));
  assign rd_data  = rd_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// tb/tb_pipe_trace_buffer.sv - self-checking bench for pipe_trace_buffer with a queue-level reference model
module tb_pipe_trace_buffer;

  localparam int CH    = 2;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int POSTN = 1;
  localparam int DW    = CH * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] probe;
  logic          sample_en, arm, trig, abort, rd_ready;
  logic          rd_valid, rd_last;
  logic [DW-1:0] rd_data;
  logic [1:0]    state;
  logic [2:0]    count;

  logic [DW-1:0] probe0;
  logic          sample_en0, arm0, trig0, abort0, rd_ready0;
  logic          rd_valid0, rd_last0;
  logic [DW-1:0] rd_data0;
  logic [1:0]    state0;
  logic [2:0]    count0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  pipe_trace_buffer #(.CH(CH), .W(W), .DEPTH(DEPTH), .POST(POSTN)) dut (
    .clk(clk), .rst(rst), .probe(probe), .sample_en(sample_en), .arm(arm), .trig(trig),
    .abort(abort), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .state(state), .count(count)
  );

  pipe_trace_buffer #(.CH(CH), .W(W), .DEPTH(DEPTH), .POST(0)) dut0 (
    .clk(clk), .rst(rst), .probe(probe0), .sample_en(sample_en0), .arm(arm0), .trig(trig0),
    .abort(abort0), .rd_valid(rd_valid0), .rd_ready(rd_ready0), .rd_data(rd_data0),
    .rd_last(rd_last0), .state(state0), .count(count0)
  );

  function automatic logic [DW-1:0] mk(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {~b, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the capture window is a bounded queue of samples, oldest at the front.
  int            m_state = 0;
  int            m_post  = 0;
  logic [DW-1:0] mq[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = 0;
      m_post  = 0;
      mq.delete();
    end else if (abort) begin
      m_state = 0;
      mq.delete();
    end else begin
      case (m_state)
        0: if (arm) begin m_state = 1; mq.delete(); end
        1: begin
          if (sample_en) begin
            mq.push_back(probe);
            if (mq.size() > DEPTH) void'(mq.pop_front());
          end
          if (trig) begin
            m_post  = POSTN;
            m_state = (POSTN == 0) ? 3 : 2;
          end
        end
        2: if (sample_en) begin
          mq.push_back(probe);
          if (mq.size() > DEPTH) void'(mq.pop_front());
          m_post--;
          if (m_post == 0) m_state = 3;
        end
        default: begin
          if (mq.size() == 0) m_state = 0;
          else if (rd_ready) begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_state = 0;
          end
        end
      endcase
    end
  end

  logic [DW-1:0] got[$];
  logic          gotl[$];
  logic          h_valid, h_last;
  logic [DW-1:0] h_data;

  always @(negedge clk) begin
    if (chk_en) begin
      bit            ev;
      logic [DW-1:0] ed;
      ev = (m_state == 3) && (mq.size() > 0);
      ed = ev ? mq[0] : '0;
      check("state",    32'(state),    32'(m_state));
      check("count",    32'(count),    32'(mq.size()));
      check("rd_valid", 32'(rd_valid), 32'(ev));
      check("rd_data",  32'(rd_data),  32'(ed));
      check("rd_last",  32'(rd_last),  32'(ev && mq.size() == 1));
    end
    h_valid = rd_valid;
    h_data  = rd_data;
    h_last  = rd_last;
  end

  always @(posedge clk) begin
    if (chk_en && rst && h_valid && rd_ready && !abort) begin
      got.push_back(h_data);
      gotl.push_back(h_last);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic samp(input int v, input bit t);
    probe     = mk(v);
    sample_en = 1'b1;
    trig      = t;
    tick();
    sample_en = 1'b0;
    trig      = 1'b0;
  endtask

  task automatic expect_readout(input string name, input int vals[4], input int n);
    check({name, "_n"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) begin
        check(name, 32'(got[i]), 32'(mk(vals[i])));
        check({name, "_last"}, 32'(gotl[i]), 32'(i == n - 1));
      end
    end
    got.delete();
    gotl.delete();
  endtask

  initial begin
    rst = 1'b0;
    probe = '0; sample_en = 0; arm = 0; trig = 0; abort = 0; rd_ready = 0;
    probe0 = '0; sample_en0 = 0; arm0 = 0; trig0 = 0; abort0 = 0; rd_ready0 = 0;
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data",  32'(rd_data), 32'd0);
    check("rst_last",  32'(rd_last), 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    tick();

    // wrap: six samples into four entries, trigger on 5
    arm = 1; tick(); arm = 0;
    check("wrap_armed", 32'(state), 32'd1);
    for (int v = 1; v <= 6; v++) samp(v, v == 5);
    check("wrap_ro", 32'(state), 32'd3);
    check("wrap_cnt", 32'(count), 32'd4);
    check("wrap_first", 32'(rd_data), 32'(mk(3)));
    rd_ready = 1;
    repeat (4) tick();
    rd_ready = 0;
    check("wrap_idle", 32'(state), 32'd0);
    expect_readout("wrap", '{3, 4, 5, 6}, 4);

    // short window with backpressure
    arm = 1; tick(); arm = 0;
    samp(8'h0A, 0); samp(8'h0B, 1); samp(8'h0C, 0);
    check("short_cnt", 32'(count), 32'd3);
    repeat (3) begin
      tick();
      check("bp_valid", 32'(rd_valid), 32'd1);
      check("bp_data", 32'(rd_data), 32'(mk(8'h0A)));
    end
    rd_ready = 1;
    repeat (3) tick();
    rd_ready = 0;
    check("short_idle", 32'(state), 32'd0);
    expect_readout("short", '{8'h0A, 8'h0B, 8'h0C, 0}, 3);

    // arm ignored while armed, stall in POST, abort during readout
    arm = 1; tick();
    samp(8'h20, 0); arm = 0;
    check("rearm_state", 32'(state), 32'd1);
    check("rearm_cnt", 32'(count), 32'd1);
    samp(8'h21, 1);
    repeat (5) tick();
    check("stall_state", 32'(state), 32'd2);
    check("stall_cnt", 32'(count), 32'd2);
    samp(8'h22, 0);
    check("stall_end", 32'(state), 32'd3);
    check("stall_endcnt", 32'(count), 32'd3);
    rd_ready = 1; abort = 1; tick(); abort = 0; rd_ready = 0;
    check("abort_state", 32'(state), 32'd0);
    check("abort_valid", 32'(rd_valid), 32'd0);
    check("abort_noxfer", 32'(got.size()), 32'd0);

    // asynchronous reset mid-POST
    arm = 1; tick(); arm = 0;
    samp(8'h31, 1);
    check("pre_rst_post", 32'(state), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_valid", 32'(rd_valid), 32'd0);
    check("async_data",  32'(rd_data), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    arm = 1; tick(); arm = 0;
    check("rst_rearm", 32'(state), 32'd1);
    abort = 1; tick(); abort = 0;

    // POST=0 build: trigger alone ends capture
    arm0 = 1; tick(); arm0 = 0;
    sample_en0 = 1;
    probe0 = mk(7); tick();
    probe0 = mk(8); tick();
    sample_en0 = 0;
    trig0 = 1; tick(); trig0 = 0;
    check("p0_state", 32'(state0), 32'd3);
    check("p0_count", 32'(count0), 32'd2);
    check("p0_data0", 32'(rd_data0), 32'(mk(7)));
    check("p0_last0", 32'(rd_last0), 32'd0);
    rd_ready0 = 1; tick();
    check("p0_data1", 32'(rd_data0), 32'(mk(8)));
    check("p0_last1", 32'(rd_last0), 32'd1);
    tick(); rd_ready0 = 0;
    check("p0_idle", 32'(state0), 32'd0);
    check("p0_novalid", 32'(rd_valid0), 32'd0);
    arm0 = 1; tick(); arm0 = 0;
    trig0 = 1; tick(); trig0 = 0;
    check("p0_empty_ro", 32'(state0), 32'd3);
    check("p0_empty_valid", 32'(rd_valid0), 32'd0);
    tick();
    check("p0_empty_idle", 32'(state0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
